axi_rr_master_arbiter: RTL and testbench



---
 rtl/axi_rr_master_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_axi_rr_master_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_master_arbiter.sv
// Master-side AXI4 arbiter: independent AW/AR arbiters (round-robin or fixed
// priority) with select locking against valid-not-ready stalls, a write-order
// queue that steers the W mux, and ID-based response select decoding.

// One address-channel arbiter: IDLE passes the combinational winner through,
// LOCK holds the select registered on the valid-not-ready stall.
module axi_rr_master_arbiter_ch #(
  parameter int M_NUM   = 4,
  parameter int M_WIDTH = 2,
  parameter int RR_MODE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [M_NUM-1:0]   i_valid,
  input  logic               i_bus_valid,
  input  logic               i_bus_ready,
  output logic [M_WIDTH-1:0] o_sel
);
  localparam int CW = M_WIDTH + 1;
  localparam logic [M_WIDTH-1:0] LAST_RST = M_WIDTH'(M_NUM - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t             r_state;
  logic [M_WIDTH-1:0] r_sel;
  logic [M_WIDTH-1:0] r_last;
  logic [M_WIDTH-1:0] w_win;
  logic [M_WIDTH-1:0] w_sel;
  logic               w_any;
  logic               w_hs;

  // Winner search: round-robin starts after r_last and wraps at M_NUM; fixed starts at 0
  always_comb begin
    logic [CW-1:0] c;
    logic          hit;
    logic          found;
    c     = '0;
    hit   = 1'b0;
    found = 1'b0;
    w_win = '0;
    for (int i = 0; i < M_NUM; i++) begin
      if (RR_MODE != 0) begin
        c = {1'b0, r_last} + CW'(i + 1);
        c = (c >= CW'(M_NUM)) ? (c - CW'(M_NUM)) : c;
      end else begin
        c = CW'(i);
      end
      hit   = !found && i_valid[c[M_WIDTH-1:0]];
      w_win = hit ? c[M_WIDTH-1:0] : w_win;
      found = found | hit;
    end
  end

  assign w_any = |i_valid;
  assign w_hs  = i_bus_valid & i_bus_ready;
  assign w_sel = (r_state == ST_LOCK) ? r_sel : (w_any ? w_win : r_sel);
  assign o_sel = w_sel;

  // State, held select and round-robin pointer; pointer moves only on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_last  <= LAST_RST;
    end else begin
      r_sel  <= w_sel;
      r_last <= w_hs ? w_sel : r_last;
      case (r_state)
        ST_IDLE: r_state <= (i_bus_valid && !i_bus_ready) ? ST_LOCK : ST_IDLE;
        ST_LOCK: r_state <= w_hs ? ST_IDLE : ST_LOCK;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

module axi_rr_master_arbiter #(
  parameter int M_NUM    = 4,
  parameter int M_WIDTH  = 2,
  parameter int M_ID     = 2,
  parameter int RR_MODE  = 1,
  parameter int WQ_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [M_NUM-1:0]        MASTER_WR_ADDR_VALID,
  input  logic [M_NUM-1:0]        MASTER_RD_ADDR_VALID,
  input  logic                    BUS_WR_ADDR_VALID,
  input  logic                    BUS_WR_ADDR_READY,
  input  logic                    BUS_WR_DATA_VALID,
  input  logic                    BUS_WR_DATA_READY,
  input  logic                    BUS_WR_DATA_LAST,
  input  logic [M_ID+M_WIDTH-1:0] BUS_WR_BACK_ID,
  input  logic                    BUS_RD_ADDR_VALID,
  input  logic                    BUS_RD_ADDR_READY,
  input  logic [M_ID+M_WIDTH-1:0] BUS_RD_BACK_ID,
  output logic [M_WIDTH-1:0]      wr_addr_master_sel,
  output logic                    wr_addr_grant_en,
  output logic [M_WIDTH-1:0]      wr_data_master_sel,
  output logic                    wr_data_sel_valid,
  output logic [M_WIDTH-1:0]      wr_resp_master_sel,
  output logic [M_WIDTH-1:0]      rd_addr_master_sel,
  output logic [M_WIDTH-1:0]      rd_data_master_sel
);
  localparam int QW   = $clog2(WQ_DEPTH);
  localparam int CNTW = QW + 1;

  logic [M_WIDTH-1:0] r_wq_mem [WQ_DEPTH];
  logic [QW-1:0]      r_wq_wptr;
  logic [QW-1:0]      r_wq_rptr;
  logic [CNTW-1:0]    r_wq_cnt;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_unused_id_bits;

  axi_rr_master_arbiter_ch #(
    .M_NUM   (M_NUM),
    .M_WIDTH (M_WIDTH),
    .RR_MODE (RR_MODE)
  ) u_aw_arb (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (MASTER_WR_ADDR_VALID),
    .i_bus_valid (BUS_WR_ADDR_VALID),
    .i_bus_ready (BUS_WR_ADDR_READY),
    .o_sel       (wr_addr_master_sel)
  );

  axi_rr_master_arbiter_ch #(
    .M_NUM   (M_NUM),
    .M_WIDTH (M_WIDTH),
    .RR_MODE (RR_MODE)
  ) u_ar_arb (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (MASTER_RD_ADDR_VALID),
    .i_bus_valid (BUS_RD_ADDR_VALID),
    .i_bus_ready (BUS_RD_ADDR_READY),
    .o_sel       (rd_addr_master_sel)
  );

  // A pop frees a slot in the same cycle, so a full queue still accepts push+pop
  assign w_full  = (r_wq_cnt == CNTW'(WQ_DEPTH));
  assign w_empty = (r_wq_cnt == '0);
  assign w_pop   = BUS_WR_DATA_VALID & BUS_WR_DATA_READY & BUS_WR_DATA_LAST & ~w_empty;
  assign w_push  = BUS_WR_ADDR_VALID & BUS_WR_ADDR_READY & (~w_full | w_pop);

  assign wr_addr_grant_en   = ~w_full;
  assign wr_data_sel_valid  = ~w_empty;
  assign wr_data_master_sel = w_empty ? '0 : r_wq_mem[r_wq_rptr];

  assign wr_resp_master_sel = BUS_WR_BACK_ID[M_ID +: M_WIDTH];
  assign rd_data_master_sel = BUS_RD_BACK_ID[M_ID +: M_WIDTH];
  assign w_unused_id_bits   = ^{BUS_WR_BACK_ID[M_ID-1:0], BUS_RD_BACK_ID[M_ID-1:0]};

  // Write-order FIFO: AW handshake pushes the granted master, last W beat pops the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wq_wptr <= '0;
      r_wq_rptr <= '0;
      r_wq_cnt  <= '0;
      for (int k = 0; k < WQ_DEPTH; k++) begin
        r_wq_mem[k] <= '0;
      end
    end else begin
      if (w_push) begin
        r_wq_mem[r_wq_wptr] <= wr_addr_master_sel;
        r_wq_wptr           <= r_wq_wptr + QW'(1);
      end
      if (w_pop) begin
        r_wq_rptr <= r_wq_rptr + QW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_wq_cnt <= r_wq_cnt + CNTW'(1);
        2'b01:   r_wq_cnt <= r_wq_cnt - CNTW'(1);
        default: r_wq_cnt <= r_wq_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rr_master_arbiter.sv
// Scoreboard bench: inst 0 = round-robin, M_NUM=3, WQ_DEPTH=2;
// inst 1 = fixed priority, M_NUM=4, WQ_DEPTH=4. Directed scenarios then random traffic.
module tb_axi_rr_master_arbiter;
  typedef struct packed {
    logic [3:0] aw_v;
    logic [3:0] ar_v;
    logic [3:0] bid;
    logic [3:0] rid;
    logic       baw_v;
    logic       baw_r;
    logic       bw_v;
    logic       bw_r;
    logic       bw_l;
    logic       bar_v;
    logic       bar_r;
  } stim_t;

  typedef struct {
    int inst;
    int aws;
    int ars;
    int wds;
    int wdv;
    int gnt;
    int wrs;
    int rds;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stim_t      cur [2];
  stim_t      nx  [2];
  logic [1:0] o_aws [2];
  logic [1:0] o_ars [2];
  logic [1:0] o_wds [2];
  logic [1:0] o_wrs [2];
  logic [1:0] o_rds [2];
  logic       o_gnt [2];
  logic       o_wdv [2];

  int n_of   [2] = '{3, 4};
  int rr_of  [2] = '{1, 0};
  int dep_of [2] = '{2, 4};

  // reference model state
  int locked [2][2];
  int held   [2][2];
  int last   [2][2];
  int csel   [2][2];
  int wq     [2][16];
  int wcnt   [2];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  axi_rr_master_arbiter #(.M_NUM(3), .M_WIDTH(2), .M_ID(2), .RR_MODE(1), .WQ_DEPTH(2)) u_dut_rr (
    .clk(clk), .rst(rst),
    .MASTER_WR_ADDR_VALID(cur[0].aw_v[2:0]), .MASTER_RD_ADDR_VALID(cur[0].ar_v[2:0]),
    .BUS_WR_ADDR_VALID(cur[0].baw_v), .BUS_WR_ADDR_READY(cur[0].baw_r),
    .BUS_WR_DATA_VALID(cur[0].bw_v), .BUS_WR_DATA_READY(cur[0].bw_r), .BUS_WR_DATA_LAST(cur[0].bw_l),
    .BUS_WR_BACK_ID(cur[0].bid),
    .BUS_RD_ADDR_VALID(cur[0].bar_v), .BUS_RD_ADDR_READY(cur[0].bar_r),
    .BUS_RD_BACK_ID(cur[0].rid),
    .wr_addr_master_sel(o_aws[0]), .wr_addr_grant_en(o_gnt[0]),
    .wr_data_master_sel(o_wds[0]), .wr_data_sel_valid(o_wdv[0]),
    .wr_resp_master_sel(o_wrs[0]), .rd_addr_master_sel(o_ars[0]),
    .rd_data_master_sel(o_rds[0])
  );

  axi_rr_master_arbiter #(.M_NUM(4), .M_WIDTH(2), .M_ID(2), .RR_MODE(0), .WQ_DEPTH(4)) u_dut_fp (
    .clk(clk), .rst(rst),
    .MASTER_WR_ADDR_VALID(cur[1].aw_v), .MASTER_RD_ADDR_VALID(cur[1].ar_v),
    .BUS_WR_ADDR_VALID(cur[1].baw_v), .BUS_WR_ADDR_READY(cur[1].baw_r),
    .BUS_WR_DATA_VALID(cur[1].bw_v), .BUS_WR_DATA_READY(cur[1].bw_r), .BUS_WR_DATA_LAST(cur[1].bw_l),
    .BUS_WR_BACK_ID(cur[1].bid),
    .BUS_RD_ADDR_VALID(cur[1].bar_v), .BUS_RD_ADDR_READY(cur[1].bar_r),
    .BUS_RD_BACK_ID(cur[1].rid),
    .wr_addr_master_sel(o_aws[1]), .wr_addr_grant_en(o_gnt[1]),
    .wr_data_master_sel(o_wds[1]), .wr_data_sel_valid(o_wdv[1]),
    .wr_resp_master_sel(o_wrs[1]), .rd_addr_master_sel(o_ars[1]),
    .rd_data_master_sel(o_rds[1])
  );

  function automatic logic [3:0] mask_of(input int i);
    return 4'((1 << n_of[i]) - 1);
  endfunction

  // search order: RR starts at last+1 modulo n, fixed starts at 0
  function automatic int pick(input int i, input int ch, input logic [3:0] v);
    int idx;
    for (int k = 1; k <= n_of[i]; k++) begin
      idx = (rr_of[i] != 0) ? (last[i][ch] + k) % n_of[i] : k - 1;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_reset(input int i);
    for (int ch = 0; ch < 2; ch++) begin
      locked[i][ch] = 0;
      held[i][ch]   = 0;
      last[i][ch]   = n_of[i] - 1;
    end
    wcnt[i] = 0;
  endfunction

  // apply the effect of the clock edge given the inputs of the cycle just ended
  function automatic void model_edge(input int i);
    logic bv, br;
    bit   pop, push;
    for (int ch = 0; ch < 2; ch++) begin
      bv = (ch == 0) ? cur[i].baw_v : cur[i].bar_v;
      br = (ch == 0) ? cur[i].baw_r : cur[i].bar_r;
      if (bv && br) begin
        last[i][ch]   = csel[i][ch];
        locked[i][ch] = 0;
      end else if (bv) begin
        locked[i][ch] = 1;
      end
      held[i][ch] = csel[i][ch];
    end
    pop  = cur[i].bw_v && cur[i].bw_r && cur[i].bw_l && (wcnt[i] > 0);
    push = cur[i].baw_v && cur[i].baw_r && ((wcnt[i] < dep_of[i]) || pop);
    if (pop) begin
      for (int k = 0; k < 15; k++) wq[i][k] = wq[i][k+1];
      wcnt[i]--;
    end
    if (push) begin
      wq[i][wcnt[i]] = csel[i][0];
      wcnt[i]++;
    end
  endfunction

  function automatic void predict(input int i);
    exp_t       e;
    logic [3:0] v;
    int         p;
    for (int ch = 0; ch < 2; ch++) begin
      v = ((ch == 0) ? cur[i].aw_v : cur[i].ar_v) & mask_of(i);
      p = pick(i, ch, v);
      csel[i][ch] = (locked[i][ch] != 0) ? held[i][ch] : ((p >= 0) ? p : held[i][ch]);
    end
    e.inst = i;
    e.aws  = csel[i][0];
    e.ars  = csel[i][1];
    e.wdv  = (wcnt[i] > 0) ? 1 : 0;
    e.wds  = (wcnt[i] > 0) ? wq[i][0] : 0;
    e.gnt  = (wcnt[i] < dep_of[i]) ? 1 : 0;
    e.wrs  = (int'(cur[i].bid) >> 2) & 3;
    e.rds  = (int'(cur[i].rid) >> 2) & 3;
    sb.push_back(e);
  endfunction

  function automatic stim_t gen_random(input int i);
    stim_t s;
    s       = '0;
    s.aw_v  = 4'($urandom) & mask_of(i);
    s.ar_v  = 4'($urandom) & mask_of(i);
    s.baw_v = ((locked[i][0] != 0) || (s.aw_v != 4'b0000)) &&
              ((wcnt[i] < dep_of[i]) || ($urandom_range(0, 7) == 0));
    s.baw_r = 1'($urandom_range(0, 1));
    s.bw_v  = (wcnt[i] > 0) && ($urandom_range(0, 1) == 1);
    s.bw_r  = 1'($urandom_range(0, 1));
    s.bw_l  = ($urandom_range(0, 2) == 0);
    s.bar_v = ((locked[i][1] != 0) || (s.ar_v != 4'b0000)) && ($urandom_range(0, 3) != 0);
    s.bar_r = 1'($urandom_range(0, 1));
    s.bid   = 4'($urandom);
    s.rid   = 4'($urandom);
    return s;
  endfunction

  task automatic clear_nx();
    nx[0] = '0;
    nx[1] = '0;
  endtask

  // one cycle: settle model on the edge, apply reset/inputs, queue expectations
  task automatic step(input bit next_rst, input bit rnd);
    @(posedge clk);
    #1;
    if (!rst) begin
      model_edge(0);
      model_edge(1);
    end
    rst = next_rst;
    if (next_rst) begin
      model_reset(0);
      model_reset(1);
    end
    for (int i = 0; i < 2; i++) begin
      cur[i] = rnd ? gen_random(i) : nx[i];
    end
    predict(0);
    predict(1);
  endtask

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s inst%0d got %0d expected %0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  // monitor: compare every queued expectation against the outputs away from the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("aw_sel",   e.inst, int'(o_aws[e.inst]), e.aws);
        chk("ar_sel",   e.inst, int'(o_ars[e.inst]), e.ars);
        chk("wd_sel",   e.inst, int'(o_wds[e.inst]), e.wds);
        chk("wd_valid", e.inst, int'(o_wdv[e.inst]), e.wdv);
        chk("grant_en", e.inst, int'(o_gnt[e.inst]), e.gnt);
        chk("wr_resp",  e.inst, int'(o_wrs[e.inst]), e.wrs);
        chk("rd_data",  e.inst, int'(o_rds[e.inst]), e.rds);
      end
    end
  end

  initial begin
    cur[0] = '0;
    cur[1] = '0;
    model_reset(0);
    model_reset(1);
    clear_nx();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // fixed-priority lock: masters 1,3; master 1 drops while stalled
    clear_nx();
    nx[1].aw_v = 4'b1010; nx[1].baw_v = 1'b1;
    step(1'b0, 1'b0);
    nx[1].aw_v = 4'b1000;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    nx[1].baw_r = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // round-robin rotation on M_NUM=3, AW and AR
    clear_nx();
    nx[0].aw_v = 4'b0111; nx[0].baw_v = 1'b1; nx[0].baw_r = 1'b1;
    nx[0].ar_v = 4'b0111; nx[0].bar_v = 1'b1; nx[0].bar_r = 1'b1;
    repeat (5) step(1'b0, 1'b0);

    // queue full with masters 2,0, then drain with LAST on beat 4
    clear_nx();
    step(1'b1, 1'b0);
    nx[0].aw_v = 4'b0100; nx[0].baw_v = 1'b1; nx[0].baw_r = 1'b1;
    step(1'b0, 1'b0);
    nx[0].aw_v = 4'b0001;
    step(1'b0, 1'b0);
    clear_nx();
    step(1'b0, 1'b0);
    nx[0].bw_v = 1'b1; nx[0].bw_r = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    nx[0].bw_l = 1'b1;
    step(1'b0, 1'b0);
    clear_nx();
    step(1'b0, 1'b0);

    // simultaneous push/pop at occupancy 1, then again while full
    nx[0].aw_v = 4'b0010; nx[0].baw_v = 1'b1; nx[0].baw_r = 1'b1;
    nx[0].bw_v = 1'b1; nx[0].bw_r = 1'b1; nx[0].bw_l = 1'b1;
    step(1'b0, 1'b0);
    clear_nx();
    nx[0].aw_v = 4'b0100; nx[0].baw_v = 1'b1; nx[0].baw_r = 1'b1;
    step(1'b0, 1'b0);
    nx[0].aw_v = 4'b0001;
    nx[0].bw_v = 1'b1; nx[0].bw_r = 1'b1; nx[0].bw_l = 1'b1;
    step(1'b0, 1'b0);
    clear_nx();
    step(1'b0, 1'b0);

    // response routing
    nx[0].rid = 4'b1001; nx[0].bid = 4'b0111;
    nx[1].rid = 4'b1001; nx[1].bid = 4'b0111;
    step(1'b0, 1'b0);

    // reset mid-burst: two queued entries and a locked AW on inst 1
    clear_nx();
    nx[1].aw_v = 4'b0100; nx[1].baw_v = 1'b1; nx[1].baw_r = 1'b1;
    step(1'b0, 1'b0);
    nx[1].aw_v = 4'b0001;
    step(1'b0, 1'b0);
    nx[1].aw_v = 4'b0010; nx[1].baw_r = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    clear_nx();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    nx[0].aw_v = 4'b0111; nx[0].baw_v = 1'b1; nx[0].baw_r = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // random traffic with occasional resets
    repeat (3000) step($urandom_range(0, 299) == 0, 1'b1);
    clear_nx();
    step(1'b0, 1'b0);

    @(negedge clk);
    #2;
    chk("sb_drained", 0, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
